contador_mod_updown: RTL and testbench

Parametrised synchronous modulo-M up/down counter. It is the successor of the 4-bit 74163-style counter used in the counter/comparator experiment. It keeps 74163 semantics: synchronous active-low clear, synchronous active-low load, ENP/ENT enables, and RCO. It adds four things: configurable width and modulus, a count direction, a built-in magnitude comparator against a reference word, and a saturating wrap counter. It sits in the datapath wherever a loadable event or address counter with a terminal-count flag is needed.

---
 rtl/contador_mod_updown.sv | 103 ++++++++++
 tb/tb_contador_mod_updown.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/contador_mod_updown.sv
// -----------------------------------------------------------------------------
// contador_mod_updown
//
// Parametrised synchronous modulo-M up/down counter with 74163-style controls.
// It keeps the 74163 behaviour: synchronous active-low clear, synchronous
// active-low load, ENP/ENT enables and a ripple carry out. It adds a count
// direction, a magnitude comparator against REF, and a saturating wrap counter.
//
// Parameters:
//   N : counter width in bits
//   M : counting modulus (2 <= M <= 2**N); Q runs through 0..M-1
//   W : width of the saturating wrap-event counter
//
// Ports:
//   CLK      in   clock; every state change happens on its rising edge
//   CLR      in   synchronous active-low clear (highest priority)
//   LD       in   synchronous active-low parallel load; D is clamped to M-1
//   D        in   parallel load data [N-1:0]
//   ENP      in   count enable (parallel)
//   ENT      in   count enable (trickle); also gates RCO
//   UP       in   direction: 1 = up, 0 = down
//   REF      in   comparator reference [N-1:0]
//   Q        out  counter state (registered) [N-1:0]
//   RCO      out  terminal count in the current direction, gated by ENT (comb)
//   EQ/GT/LT out  unsigned compare of Q against REF (comb, exactly one is set)
//   WRAP     out  registered pulse in the cycle after a wrap edge
//   WRAP_CNT out  wraps since clear, saturating at all-ones [W-1:0]
// -----------------------------------------------------------------------------
module contador_mod_updown #(
    parameter int N = 4,
    parameter int M = 16,
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         LD,
    input  logic [N-1:0] D,
    input  logic         ENP,
    input  logic         ENT,
    input  logic         UP,
    input  logic [N-1:0] REF,
    output logic [N-1:0] Q,
    output logic         RCO,
    output logic         EQ,
    output logic         GT,
    output logic         LT,
    output logic         WRAP,
    output logic [W-1:0] WRAP_CNT
);

    // Largest legal state. M may equal 2**N, so M-1 always fits in N bits.
    localparam logic [N-1:0] Q_MAX = N'(M - 1);

    logic         count_en;
    logic         at_terminal;
    logic         wrap_evt;
    logic [N-1:0] q_next_count;
    logic [N-1:0] d_clamped;

    always_comb begin
        count_en     = ENP & ENT;
        // Terminal state depends on direction: M-1 going up, 0 going down.
        at_terminal  = UP ? (Q == Q_MAX) : (Q == '0);
        wrap_evt     = count_en & at_terminal;
        d_clamped    = (D > Q_MAX) ? Q_MAX : D;
        q_next_count = Q;
        if (UP) begin
            q_next_count = at_terminal ? '0 : Q + N'(1);
        end else begin
            q_next_count = at_terminal ? Q_MAX : Q - N'(1);
        end
    end

    // RCO ignores ENP so that chained stages can cascade ENT <= RCO.
    assign RCO = ENT & at_terminal;
    assign EQ  = (Q == REF);
    assign GT  = (Q >  REF);
    assign LT  = (Q <  REF);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the clear lives inside the clocked block, so it is
    // purely synchronous with no asynchronous path.
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            Q        <= '0;
            WRAP     <= 1'b0;
            WRAP_CNT <= '0;
        end else if (!LD) begin
            Q    <= d_clamped;
            WRAP <= 1'b0;
        end else if (count_en) begin
            Q    <= q_next_count;
            WRAP <= wrap_evt;
            // Saturate rather than roll over once all ones is reached.
            if (wrap_evt && (WRAP_CNT != {W{1'b1}})) begin
                WRAP_CNT <= WRAP_CNT + W'(1);
            end
        end else begin
            WRAP <= 1'b0;
        end
    end

endmodule

// File: tb/tb_contador_mod_updown.sv
// -----------------------------------------------------------------------------
// tb_contador_mod_updown
//
// Self-checking bench for contador_mod_updown (N=4, M=10, W=2).
// A behavioural model written with modular arithmetic tracks the expected
// state. A compare process checks every DUT output against it on each falling
// edge. A directed sequence pins the model with hand-computed literal values,
// and a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_contador_mod_updown;

    localparam int N = 4;
    localparam int M = 10;
    localparam int W = 2;
    localparam int CNT_SAT = (1 << W) - 1;

    logic         CLK = 1'b0;
    logic         CLR, LD, ENP, ENT, UP;
    logic [N-1:0] D, REF;
    logic [N-1:0] Q;
    logic         RCO, EQ, GT, LT, WRAP;
    logic [W-1:0] WRAP_CNT;

    int total = 0;
    int bad   = 0;

    contador_mod_updown #(.N(N), .M(M), .W(W)) dut (
        .CLK(CLK), .CLR(CLR), .LD(LD), .D(D), .ENP(ENP), .ENT(ENT), .UP(UP),
        .REF(REF), .Q(Q), .RCO(RCO), .EQ(EQ), .GT(GT), .LT(LT),
        .WRAP(WRAP), .WRAP_CNT(WRAP_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_q    = 0;
    int m_wrap = 0;
    int m_cnt  = 0;
    bit m_valid = 1'b0;

    always @(posedge CLK) begin
        if (CLR === 1'b0) begin
            m_q     <= 0;
            m_wrap  <= 0;
            m_cnt   <= 0;
            m_valid <= 1'b1;
        end else if (LD === 1'b0) begin
            m_q    <= (int'(D) > M - 1) ? M - 1 : int'(D);
            m_wrap <= 0;
        end else if (ENP && ENT) begin
            int  nq;
            bit  wrapped;
            if (UP) begin
                nq      = (m_q + 1) % M;
                wrapped = (m_q + 1 >= M);
            end else begin
                nq      = (m_q + M - 1) % M;
                wrapped = (m_q - 1 < 0);
            end
            m_q    <= nq;
            m_wrap <= int'(wrapped);
            if (wrapped) m_cnt <= (m_cnt + 1 > CNT_SAT) ? CNT_SAT : m_cnt + 1;
        end else begin
            m_wrap <= 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        if (m_valid) begin
            bit exp_rco;
            exp_rco = ENT && (UP ? (m_q == M - 1) : (m_q == 0));
            check("q",        32'(Q),        32'(m_q));
            check("wrap",     32'(WRAP),     32'(m_wrap));
            check("wrap_cnt", 32'(WRAP_CNT), 32'(m_cnt));
            check("rco",      32'(RCO),      32'(exp_rco));
            check("eq",       32'(EQ),       32'(m_q == int'(REF)));
            check("gt",       32'(GT),       32'(m_q >  int'(REF)));
            check("lt",       32'(LT),       32'(m_q <  int'(REF)));
            check("onehot",   32'(EQ + GT + LT), 32'd1);
        end
    end

    // Advance one rising edge; return just after it so outputs have settled.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        CLR = 1'b0; LD = 1'b1; D = '0; ENP = 1'b0; ENT = 1'b1; UP = 1'b1; REF = '0;

        // Clear / reset values
        step();
        check("rst_q",    32'(Q), 32'd0);
        check("rst_wrap", 32'(WRAP), 32'd0);
        check("rst_cnt",  32'(WRAP_CNT), 32'd0);
        check("rst_eq",   32'(EQ), 32'd1);
        check("rst_rco",  32'(RCO), 32'd0);

        // Modulo up-count and wrap
        CLR = 1'b1; ENP = 1'b1; ENT = 1'b1; UP = 1'b1;
        step(9);
        check("up_q9",    32'(Q), 32'd9);
        check("up_rco9",  32'(RCO), 32'd1);
        step();
        check("up_wrap_q",    32'(Q), 32'd0);
        check("up_wrap_pulse", 32'(WRAP), 32'd1);
        check("up_rco0",  32'(RCO), 32'd0);
        step(2);
        check("up_q2",    32'(Q), 32'd2);
        check("up_wrap_low", 32'(WRAP), 32'd0);
        check("up_cnt1",  32'(WRAP_CNT), 32'd1);

        // Enable gating
        step(3);
        check("gate_q5",  32'(Q), 32'd5);
        ENT = 1'b0;
        step(2);
        check("ent0_hold", 32'(Q), 32'd5);
        ENT = 1'b1; ENP = 1'b0;
        step(2);
        check("enp0_hold", 32'(Q), 32'd5);
        ENT = 1'b0; LD = 1'b0; D = 4'd9;
        step();
        check("ld9_q",    32'(Q), 32'd9);
        check("ent0_rco", 32'(RCO), 32'd0);
        ENT = 1'b1;
        #1;
        check("ent1_rco", 32'(RCO), 32'd1);

        // Load and clamp
        LD = 1'b0; D = 4'd7; REF = 4'd3;
        step();
        check("ld7_q",  32'(Q), 32'd7);
        check("ld7_gt", 32'(GT), 32'd1);
        D = 4'd13;
        step();
        check("clamp_q", 32'(Q), 32'd9);
        CLR = 1'b0;
        step();
        check("clr_over_ld", 32'(Q), 32'd0);

        // Direction change at terminal count
        CLR = 1'b1; LD = 1'b0; D = 4'd9; ENP = 1'b1; ENT = 1'b1; UP = 1'b1;
        step();
        LD = 1'b1; UP = 1'b0;
        step();
        check("dir_q8",   32'(Q), 32'd8);
        check("dir_wrap", 32'(WRAP), 32'd0);
        check("dir_cnt",  32'(WRAP_CNT), 32'd0);

        // Down-count wrap and saturation
        LD = 1'b0; D = 4'd0;
        step();
        LD = 1'b1; UP = 1'b0;
        step();
        check("dn_q9",   32'(Q), 32'd9);
        check("dn_wrap", 32'(WRAP), 32'd1);
        check("dn_cnt1", 32'(WRAP_CNT), 32'd1);
        step(40);
        check("sat_q",   32'(Q), 32'd9);
        check("sat_cnt", 32'(WRAP_CNT), 32'd3);
        step(3);
        CLR = 1'b0;
        step();
        check("midclr_q",   32'(Q), 32'd0);
        check("midclr_cnt", 32'(WRAP_CNT), 32'd0);

        // Randomized phase
        for (int i = 0; i < 2000; i++) begin
            CLR = ($urandom_range(31) != 0);
            LD  = ($urandom_range(7) != 0);
            ENP = ($urandom_range(3) != 0);
            ENT = ($urandom_range(3) != 0);
            UP  = 1'($urandom_range(1));
            D   = N'($urandom_range(15));
            REF = N'($urandom_range(15));
            step();
        end

        @(negedge CLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
